// File: rtl/fp_cfg_pkg.sv
// Shared floating-point configuration: standard format widths, the exponent
// bias helper and the converter state encoding.
package fp_cfg_pkg;

    localparam int unsigned FP32_EXP_W = 8;
    localparam int unsigned FP32_MAN_W = 23;
    localparam int unsigned FP16_EXP_W = 5;
    localparam int unsigned FP16_MAN_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } conv_state_t;

    // Exponent bias for an exp_w-bit exponent field: 2^(exp_w-1)-1.
    function automatic int unsigned fp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 32'd1)) - 32'd1;
    endfunction

endpackage

// File: rtl/int_to_fp_conv_if.sv
// Handshake bundle for int_to_fp_conv.
//   in_valid/in_ready/in_data/in_signed    : integer operand channel
//   out_valid/out_ready/out_data           : {sign, exponent, mantissa} result channel
//   out_inexact/out_overflow               : result flags, qualified by out_valid
// master = producer/consumer side, slave = converter side.
interface int_to_fp_conv_if #(
    parameter int unsigned INT_W = 32,
    parameter int unsigned EXP_W = fp_cfg_pkg::FP32_EXP_W,
    parameter int unsigned MAN_W = fp_cfg_pkg::FP32_MAN_W
);
    logic                   in_valid;
    logic                   in_ready;
    logic [INT_W-1:0]       in_data;
    logic                   in_signed;
    logic                   out_valid;
    logic                   out_ready;
    logic [EXP_W+MAN_W:0]   out_data;
    logic                   out_inexact;
    logic                   out_overflow;

    modport master (
        output in_valid, in_data, in_signed, out_ready,
        input  in_ready, out_valid, out_data, out_inexact, out_overflow
    );

    modport slave (
        input  in_valid, in_data, in_signed, out_ready,
        output in_ready, out_valid, out_data, out_inexact, out_overflow
    );
endinterface

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even on a normalised mantissa.
//   man/guard/sticky/exp : truncated mantissa (no hidden bit), guard bit,
//                          OR of the bits below guard, biased exponent
//   rnd_man_c/rnd_exp_c  : rounded mantissa and exponent (infinity on overflow)
//   inexact_c/overflow_c : discarded bits nonzero / exponent reached all-ones
module fp_round_rne #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic [MAN_W-1:0] man,
    input  logic             guard,
    input  logic             sticky,
    input  logic [EXP_W-1:0] exp,
    output logic [MAN_W-1:0] rnd_man_c,
    output logic [EXP_W-1:0] rnd_exp_c,
    output logic             inexact_c,
    output logic             overflow_c
);
    logic             round_up;
    logic [MAN_W:0]   man_sum;
    logic [EXP_W-1:0] exp_sum;

    // Increment on carry-out leaves the low MAN_W bits zero, which is exactly
    // the renormalised mantissa, so only the exponent needs adjusting.
    always_comb begin
        round_up   = guard & (sticky | man[0]);
        man_sum    = {1'b0, man} + (MAN_W+1)'(round_up);
        exp_sum    = exp + EXP_W'(man_sum[MAN_W]);
        rnd_man_c  = man_sum[MAN_W-1:0];
        rnd_exp_c  = exp_sum;
        inexact_c  = guard | sticky;
        overflow_c = 1'b0;
        if (&exp_sum) begin
            rnd_man_c  = '0;
            overflow_c = 1'b1;
        end
    end
endmodule

// File: rtl/int_to_fp_conv.sv
// Multi-cycle integer to floating-point converter with RNE rounding.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : int_to_fp_conv_if slave; accepts one operand in IDLE, normalises
//              one bit per cycle, rounds, then holds the result until taken.
module int_to_fp_conv
    import fp_cfg_pkg::*;
#(
    parameter int unsigned INT_W = 32,
    parameter int unsigned EXP_W = FP32_EXP_W,
    parameter int unsigned MAN_W = FP32_MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    int_to_fp_conv_if.slave  bus
);
    localparam int unsigned BIAS    = fp_bias(EXP_W);
    localparam int unsigned EXP_MAX = (32'd1 << EXP_W) - 32'd1;
    localparam int unsigned OUT_W   = 1 + EXP_W + MAN_W;
    localparam int unsigned FRAC_W  = INT_W - 1;
    localparam int unsigned EXT_W   = FRAC_W + MAN_W + 2;

    // Largest input exponent must leave room below the all-ones code.
    if ((INT_W < 2) || (INT_W - 1 + BIAS > EXP_MAX - 1)) begin : g_bad_cfg
        $error("int_to_fp_conv: INT_W/EXP_W combination not representable");
    end

    conv_state_t        state, state_nxt;

    logic               sign_q, sign_d;
    logic [INT_W-1:0]   mag_q, mag_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               inexact_q, inexact_d;
    logic               overflow_q, overflow_d;

    logic               in_xfer_c;
    logic               out_xfer_c;
    logic               in_sign_c;
    logic [INT_W-1:0]   in_mag_c;

    logic [EXT_W-1:0]   ext_c;
    logic [MAN_W-1:0]   man_c;
    logic               guard_c;
    logic               sticky_c;
    logic [MAN_W-1:0]   rnd_man_c;
    logic [EXP_W-1:0]   rnd_exp_c;
    logic               rnd_inexact_c;
    logic               rnd_overflow_c;

    // Handshakes and operand decode; negation of the most negative value
    // wraps to 2^(INT_W-1), which is the correct unsigned magnitude.
    always_comb begin
        in_xfer_c  = bus.in_valid && (state == IDLE);
        out_xfer_c = out_valid_q && bus.out_ready;
        in_sign_c  = bus.in_signed & bus.in_data[INT_W-1];
        in_mag_c   = in_sign_c ? (~bus.in_data + INT_W'(1)) : bus.in_data;
    end

    // Fraction bits below the leading one, right-padded so that mantissa,
    // guard and sticky always exist whatever INT_W is relative to MAN_W.
    always_comb begin
        ext_c    = {mag_q[INT_W-2:0], {(MAN_W+2){1'b0}}};
        man_c    = ext_c[EXT_W-1 -: MAN_W];
        guard_c  = ext_c[EXT_W-1-MAN_W];
        sticky_c = |ext_c[EXT_W-2-MAN_W:0];
    end

    fp_round_rne #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .man        (man_c),
        .guard      (guard_c),
        .sticky     (sticky_c),
        .exp        (exp_q),
        .rnd_man_c  (rnd_man_c),
        .rnd_exp_c  (rnd_exp_c),
        .inexact_c  (rnd_inexact_c),
        .overflow_c (rnd_overflow_c)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_xfer_c) state_nxt = (in_mag_c == '0) ? DONE : NORM;
            NORM:    if (mag_q[INT_W-1]) state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    if (out_xfer_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath next values. out_valid trails entry into DONE by one
    // cycle so the result register is already settled when it is presented.
    always_comb begin
        sign_d      = sign_q;
        mag_d       = mag_q;
        exp_d       = exp_q;
        in_ready_d  = (state_nxt == IDLE);
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        inexact_d   = inexact_q;
        overflow_d  = overflow_q;
        case (state)
            IDLE: begin
                if (in_xfer_c) begin
                    sign_d     = in_sign_c;
                    mag_d      = in_mag_c;
                    exp_d      = EXP_W'(INT_W - 1 + BIAS);
                    out_data_d = '0;
                    inexact_d  = 1'b0;
                    overflow_d = 1'b0;
                end
            end
            NORM: begin
                if (!mag_q[INT_W-1]) begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - EXP_W'(1);
                end
            end
            ROUND: begin
                out_data_d = {sign_q, rnd_exp_c, rnd_man_c};
                inexact_d  = rnd_inexact_c;
                overflow_d = rnd_overflow_c;
            end
            DONE: begin
                out_valid_d = !out_xfer_c;
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q      <= 1'b0;
            mag_q       <= '0;
            exp_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            inexact_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            exp_q       <= exp_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            inexact_q   <= inexact_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_inexact  = inexact_q;
    assign bus.out_overflow = overflow_q;
endmodule
